// File: rtl/debounce_entrada_pkg.sv
// Shared timing defaults for the input-conditioning blocks (board-clock based),
// plus the helper that sizes the stability counters.
package debounce_entrada_pkg;

    localparam int SYNC_STAGES_DEF     = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 1000;

    // Counter must be able to represent 0..DEBOUNCE_CYCLES.
    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES_DEF);

endpackage

// File: rtl/debounce_entrada_canal.sv
// One debounced channel: synchronizer chain, stability counter and the
// registered level/instability outputs.
module debounce_canal
    import debounce_entrada_pkg::*;
#(
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic entrada_bit,
    output logic saida_bit,
    output logic instavel_bit
);

    localparam int              CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   saida_q, saida_d;
    logic                   instavel_q, instavel_d;
    logic                   sinc;

    assign sinc = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], entrada_bit};
    end

    // Any cycle where sinc matches saida (including a bounce back) restarts the count.
    always_comb begin
        cnt_d      = '0;
        saida_d    = saida_q;
        instavel_d = 1'b0;
        if (sinc != saida_q) begin
            if (cnt_q == CNT_LAST) begin
                saida_d = sinc;
            end else begin
                cnt_d      = cnt_q + CW'(1);
                instavel_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            saida_q    <= 1'b0;
            instavel_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            cnt_q      <= cnt_d;
            saida_q    <= saida_d;
            instavel_q <= instavel_d;
        end
    end

    assign saida_bit    = saida_q;
    assign instavel_bit = instavel_q;

endmodule

// File: rtl/debounce_entrada.sv
// Multi-channel debouncer for raw button/switch inputs; feeds the rising-edge
// detector stage. Each channel is an independent debounce_canal.
module debounce_entrada
    import debounce_entrada_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] entrada,
    output logic [WIDTH-1:0] saida,
    output logic [WIDTH-1:0] instavel
);

    for (genvar g = 0; g < WIDTH; g++) begin : g_canal
        debounce_canal #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_canal (
            .clk          (clk),
            .rst          (rst),
            .entrada_bit  (entrada[g]),
            .saida_bit    (saida[g]),
            .instavel_bit (instavel[g])
        );
    end

endmodule

// File: tb/tb_debounce_entrada.sv
// Bench for debounce_entrada: directed literal checks plus a randomized run,
// with a history-based model checked on every clock.
module tb_debounce_entrada;

    localparam int WIDTH = 2;
    localparam int SS    = 2;
    localparam int DC    = 4;
    localparam int MAXE  = 8192;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] entrada;
    logic [WIDTH-1:0] saida;
    logic [WIDTH-1:0] instavel;

    int tests_run    = 0;
    int tests_failed = 0;

    debounce_entrada #(
        .WIDTH           (WIDTH),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .entrada  (entrada),
        .saida    (saida),
        .instavel (instavel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] ent_h [0:MAXE-1];
    bit               rst_h [0:MAXE-1];
    int               last_evt [WIDTH];
    logic [WIDTH-1:0] m_saida;
    logic [WIDTH-1:0] m_inst;
    bit               mdl_valid = 1'b0;
    int               n_edge    = 0;

    // Level presented to the debounce logic at edge k: entrada from SS edges
    // earlier, unless a reset cleared the chain in between.
    function automatic logic sinc_seen(input int k, input int c);
        if (k < SS) return 1'b0;
        for (int j = 1; j <= SS; j++) begin
            if (rst_h[k-j]) return 1'b0;
        end
        return ent_h[k-SS][c];
    endfunction

    initial begin
        for (int c = 0; c < WIDTH; c++) last_evt[c] = 0;
        m_saida = '0;
        m_inst  = '0;
        forever begin
            @(posedge clk);
            if (n_edge < MAXE) begin
                ent_h[n_edge] = entrada;
                rst_h[n_edge] = !rst;
                if (!rst) begin
                    m_saida   = '0;
                    m_inst    = '0;
                    mdl_valid = 1'b1;
                    for (int c = 0; c < WIDTH; c++) last_evt[c] = n_edge;
                end else begin
                    for (int c = 0; c < WIDTH; c++) begin
                        automatic logic s      = sinc_seen(n_edge, c);
                        automatic bit   commit = 1'b1;
                        for (int j = 0; j < DC; j++) begin
                            if (n_edge - j <= last_evt[c] ||
                                sinc_seen(n_edge - j, c) == m_saida[c])
                                commit = 1'b0;
                        end
                        if (commit) begin
                            m_saida[c]  = s;
                            m_inst[c]   = 1'b0;
                            last_evt[c] = n_edge;
                        end else begin
                            m_inst[c] = (s != m_saida[c]);
                        end
                    end
                end
                n_edge++;
            end
            #1;
            if (mdl_valid) begin
                tests_run += 2;
                if (saida !== m_saida) begin
                    tests_failed++;
                    $display("[TB] FAIL model_saida edge %0d: got %b, expected %b", n_edge, saida, m_saida);
                end
                if (instavel !== m_inst) begin
                    tests_failed++;
                    $display("[TB] FAIL model_instavel edge %0d: got %b, expected %b", n_edge, instavel, m_inst);
                end
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic [WIDTH-1:0] e, input int n);
        rst     = r;
        entrada = e;
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] exp_s,
                               input logic [WIDTH-1:0] exp_i);
        tests_run++;
        if (saida !== exp_s || instavel !== exp_i) begin
            tests_failed++;
            $display("[TB] FAIL %s: saida=%b instavel=%b, expected saida=%b instavel=%b",
                     name, saida, instavel, exp_s, exp_i);
        end
    endtask

    initial begin
        rst     = 1'b0;
        entrada = 2'b11;

        // Reset held for 3 edges with inputs high, then release.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 2'b11, 1);
            checkOutput("reset_hold", 2'b00, 2'b00);
        end
        applyStimulus(1'b1, 2'b11, 2);
        checkOutput("rel_edge2", 2'b00, 2'b00);
        applyStimulus(1'b1, 2'b11, 1);
        checkOutput("rel_edge3", 2'b00, 2'b11);
        applyStimulus(1'b1, 2'b11, 2);
        checkOutput("rel_edge5", 2'b00, 2'b11);
        applyStimulus(1'b1, 2'b11, 1);
        checkOutput("rel_edge6", 2'b11, 2'b00);

        // Release of both channels, then a clean press on channel 0.
        applyStimulus(1'b1, 2'b00, 5);
        checkOutput("release_edge5", 2'b11, 2'b11);
        applyStimulus(1'b1, 2'b00, 1);
        checkOutput("release_edge6", 2'b00, 2'b00);
        applyStimulus(1'b1, 2'b01, 5);
        checkOutput("press0_edge5", 2'b00, 2'b01);
        applyStimulus(1'b1, 2'b01, 1);
        checkOutput("press0_edge6", 2'b01, 2'b00);

        // Bounce: 1,1,1,0,1,1,1,1 on channel 0 starting from a settled 0.
        applyStimulus(1'b1, 2'b00, 8);
        checkOutput("bounce_base", 2'b00, 2'b00);
        applyStimulus(1'b1, 2'b01, 3);
        applyStimulus(1'b1, 2'b00, 1);
        applyStimulus(1'b1, 2'b01, 1);
        checkOutput("bounce_edge5", 2'b00, 2'b01);
        applyStimulus(1'b1, 2'b01, 1);
        checkOutput("bounce_edge6", 2'b00, 2'b00);
        applyStimulus(1'b1, 2'b01, 3);
        checkOutput("bounce_edge9", 2'b00, 2'b01);
        applyStimulus(1'b1, 2'b01, 1);
        checkOutput("bounce_edge10", 2'b01, 2'b00);

        // Single-cycle glitch on channel 1.
        applyStimulus(1'b1, 2'b11, 1);
        applyStimulus(1'b1, 2'b01, 2);
        checkOutput("glitch_edge3", 2'b01, 2'b10);
        applyStimulus(1'b1, 2'b01, 1);
        checkOutput("glitch_edge4", 2'b01, 2'b00);
        applyStimulus(1'b1, 2'b01, 6);
        checkOutput("glitch_after", 2'b01, 2'b00);

        // Independent channels: ch0 rises 2 edges before ch1, then both released.
        applyStimulus(1'b1, 2'b00, 8);
        applyStimulus(1'b1, 2'b01, 2);
        applyStimulus(1'b1, 2'b11, 4);
        checkOutput("indep_ch0", 2'b01, 2'b10);
        applyStimulus(1'b1, 2'b11, 2);
        checkOutput("indep_ch1", 2'b11, 2'b00);
        applyStimulus(1'b1, 2'b00, 5);
        checkOutput("indep_fall5", 2'b11, 2'b11);
        applyStimulus(1'b1, 2'b00, 1);
        checkOutput("indep_fall6", 2'b00, 2'b00);

        // Reset in the middle of a count discards it.
        applyStimulus(1'b1, 2'b01, 4);
        checkOutput("midcount", 2'b00, 2'b01);
        applyStimulus(1'b0, 2'b01, 1);
        checkOutput("midcount_rst", 2'b00, 2'b00);
        applyStimulus(1'b1, 2'b01, 5);
        checkOutput("midcount_edge5", 2'b00, 2'b01);
        applyStimulus(1'b1, 2'b01, 1);
        checkOutput("midcount_edge6", 2'b01, 2'b00);

        // Randomized run: sparse toggles give a mix of glitches and stable levels.
        for (int i = 0; i < 3000; i++) begin
            automatic logic [WIDTH-1:0] e = entrada;
            automatic logic             r = ($urandom_range(0, 199) != 0);
            for (int c = 0; c < WIDTH; c++) begin
                if ($urandom_range(0, 5) == 0) e[c] = ~e[c];
            end
            applyStimulus(r, e, 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/debounce_entrada.md
Name: debounce_entrada

Overview:
- Conditions raw, asynchronous, bouncing button/switch inputs into clean, clock-synchronous levels.
- Sits directly upstream of the rising-edge detector stage; its `saida` drives that stage's `entrada`.
- Each channel is independent: a synchronizer chain, then a stability counter that commits a new level only after it has held for a programmable number of cycles.

Parameters:
- WIDTH, 2, number of independent input channels.
- SYNC_STAGES, 2, flip-flop depth of the per-channel synchronizer; must be ≥2.
- DEBOUNCE_CYCLES, 1000, consecutive stable cycles required before the output changes; must be ≥1.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset (sampled on rising clk edge; asserted when 0).
- entrada  input  WIDTH  raw asynchronous inputs, may bounce.
- saida  output  WIDTH  debounced, synchronized levels, registered.
- instavel  output  WIDTH  per channel, 1 while synchronized input differs from saida (debounce in progress), registered.

Behaviour:
- Reset (rst==0 at a clk edge):
  - all synchronizer flops, saida, instavel and counters go to 0.
  - Reset has priority over every other event, including mid-count; a pending change is discarded.
- Synchronizer: per channel, a shift chain of SYNC_STAGES flops; `sinc` is the last stage. It carries no debounce logic.
- Per-channel counter `cnt`, width $clog2(DEBOUNCE_CYCLES+1), unsigned, never wraps. Each edge, out of reset:
  - sinc == saida: cnt <= 0; instavel <= 0; saida holds. This covers a bounce back to the old level, which restarts the count.
  - sinc != saida and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1; instavel <= 1.
  - sinc != saida and cnt == DEBOUNCE_CYCLES-1: saida <= sinc; cnt <= 0; instavel <= 0.
- Latency:
  - An input change that is stable from before clk edge k appears on saida after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - Equivalently, saida updates after DEBOUNCE_CYCLES consecutive edges with sinc != saida.
- DEBOUNCE_CYCLES==1: saida follows sinc with one extra register of delay; instavel never asserts.
- Pulses shorter than DEBOUNCE_CYCLES cycles (after synchronization) never reach saida.
- Channels are fully independent; simultaneous changes on several channels are each timed separately.
- Release (1→0) is debounced identically to press (0→1).
- saida changes at most once per DEBOUNCE_CYCLES cycles per channel.
- No combinational path from entrada to any output.

Decomposition:
- Shared package: default constants for SYNC_STAGES and DEBOUNCE_CYCLES, and a helper constant for counter width (CNT_W = $clog2(DEBOUNCE_CYCLES+1)).
- Timing defaults derive from the board clock; the same package is reused by other input-conditioning blocks.
- One natural sub-module: `debounce_canal`, a single channel containing synchronizer, counter and output flop with ports clk, rst, entrada_bit, saida_bit, instavel_bit.
- Top level instantiates WIDTH copies via generate.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4 unless stated):
- Reset behaviour:
  - Stimulus: hold rst=0 for 3 edges with entrada=2'b11, then release.
  - Response: saida=2'b00 and instavel=2'b00 during reset. After release, saida=2'b11 exactly 2+4 edges after the first edge with rst=1; instavel=2'b11 for the intermediate edges.
- Clean press on channel 0:
  - Stimulus: entrada 2'b00→2'b01 and held.
  - Response: saida[0] rises on the 6th edge after the change; saida[1] stays 0 throughout.
- Bounce rejection:
  - Stimulus: entrada[0] pattern 1,1,1,0,1,1,1,1 (one cycle per value, held 1 afterwards).
  - Response: saida[0] does not rise until 4 consecutive synchronized 1s after the glitch, i.e. a 3-cycle pulse followed by a 0 is rejected.
- Short glitch:
  - Stimulus: a single-cycle 1 on entrada[1].
  - Response: instavel[1] pulses for 1 cycle (delayed by 2); saida[1] stays 0.
- Independent channels:
  - Stimulus: entrada[0] rises at edge 10 and entrada[1] rises at edge 12.
  - Response: saida[0] rises at edge 16 and saida[1] at edge 18.
  - Stimulus: release both at edge 30.
  - Response: both fall at edge 36.
- Reset mid-count:
  - Stimulus: entrada[0] rises; after 2 counting edges apply rst=0 for 1 edge, then release with entrada still 1.
  - Response: saida[0] is 0 after reset; the count restarts from 0, so saida[0] rises a full 2+4 edges after release.
